// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect one push-button into event pulses.
// Auto-repeat while held is enabled by defining BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 12_500_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_t;

    state_t        state, state_n;
    logic          s1, s2, sync, tog, rise, fall, long_n;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt, hold_n;

    assign sync = s2 ^ ACTIVE_LOW;
    assign tog  = (sync != level) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise = tog && !level;
    assign fall = tog && level;

    // Flops reset to the idle pin value so a key held through reset must re-debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= ACTIVE_LOW;
            s2            <= ACTIVE_LOW;
            deb_cnt       <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= btn_raw;
            s2            <= s1;
            deb_cnt       <= (sync == level || tog) ? '0 : deb_cnt + 1'b1;
            level         <= level ^ tog;
            press         <= rise;
            release_pulse <= fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RELEASED;
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            long_press <= long_n;
        end
    end

    // hold_cnt stops at HOLD_CYCLES once HELD is entered, so it never wraps.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        long_n  = 1'b0;
        if (fall) begin
            state_n = RELEASED;
            hold_n  = '0;
        end else if (state == RELEASED && rise) begin
            state_n = PRESSED;
            hold_n  = '0;
        end else if (state == PRESSED) begin
            hold_n = hold_cnt + 1'b1;
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                state_n = HELD;
                long_n  = 1'b1;
            end
        end
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rep_cnt, rep_n;
    logic          rep_wrap, rpt_n;

    assign rep_wrap = rep_cnt == RW'(REPEAT_CYCLES - 1);

    always_comb begin
        rep_n = '0;
        rpt_n = 1'b0;
        if (state == HELD && !fall) begin
            rep_n = rep_wrap ? '0 : rep_cnt + 1'b1;
            rpt_n = rep_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_n;
            repeat_pulse <= rpt_n;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif
endmodule
